// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Byte-oriented SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB
//               first. One byte per tx_en_i strobe, received byte returned
//               with a one-cycle rx_en_o strobe. CSN may be held low across
//               several bytes and released later with cs_release_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
  parameter int unsigned HALF_PERIOD = 3   // clk6x cycles per SCK half-period, 2..255
) (
  input  logic       clk6x,
  input  logic       resetn,
  output logic       spi_clk_o,
  output logic       spi_csn_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  input  logic       cs_keep_i,
  input  logic       cs_release_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_en_o,
  output logic       busy_o
);

  // Last count value of a half-period; the counter runs 0..HP_LAST.
  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_HIGH    = 3'd2,
    S_LOW     = 3'd3,
    S_DONE    = 3'd4,
    S_HOLD    = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [2:0] bit_q;
  logic [6:0] tx_sh_q;      // bits still to be sent after the one on MOSI
  logic [6:0] rx_sh_q;      // bits received so far in this byte
  logic       keep_q;
  logic       rel_phase_q;  // 0: CSN hold time, 1: minimum deselect time
  logic       miso_q;
  logic       sck_q;
  logic       csn_q;
  logic       mosi_q;
  logic [7:0] rx_byte_q;
  logic       rx_en_q;
  logic       busy_q;
  logic       half_done;

  // Half-period counter increment and terminal-count detect.
  always_comb begin
    cnt_d     = cnt_q + 8'd1;
    half_done = (cnt_q == HP_LAST);
  end

  // MISO is asynchronous to clk6x: register it once every cycle.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) miso_q <= 1'b0;
    else         miso_q <= spi_miso_i;
  end

  // Transfer sequencer; every SPI-side and user-side output is registered here.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 3'd0;
      tx_sh_q     <= 7'd0;
      rx_sh_q     <= 7'd0;
      keep_q      <= 1'b0;
      rel_phase_q <= 1'b0;
      sck_q       <= 1'b0;
      csn_q       <= 1'b1;
      mosi_q      <= 1'b0;
      rx_byte_q   <= 8'd0;
      rx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (tx_en_i) begin
            // Start a byte; in HOLD CSN is already low so no extra edge.
            csn_q   <= 1'b0;
            mosi_q  <= tx_byte_i[7];
            tx_sh_q <= tx_byte_i[6:0];
            keep_q  <= cs_keep_i;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= S_SETUP;
          end else if ((state_q == S_HOLD) && cs_release_i) begin
            busy_q      <= 1'b1;
            cnt_q       <= 8'd0;
            rel_phase_q <= 1'b0;
            state_q     <= S_RELEASE;
          end
        end
        S_SETUP, S_LOW: begin
          if (half_done) begin
            sck_q   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= S_HIGH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HIGH: begin
          if (half_done) begin
            sck_q   <= 1'b0;
            cnt_q   <= 8'd0;
            rx_sh_q <= {rx_sh_q[5:0], miso_q};
            if (bit_q == 3'd7) begin
              bit_q     <= 3'd0;
              rx_byte_q <= {rx_sh_q, miso_q};
              rx_en_q   <= 1'b1;
              busy_q    <= ~keep_q;
              state_q   <= S_DONE;
            end else begin
              bit_q   <= bit_q + 3'd1;
              mosi_q  <= tx_sh_q[6];
              tx_sh_q <= {tx_sh_q[5:0], 1'b0};
              state_q <= S_LOW;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          // The DONE cycle already counts as the first CSN hold cycle.
          cnt_q       <= 8'd1;
          rel_phase_q <= 1'b0;
          state_q     <= keep_q ? S_HOLD : S_RELEASE;
        end
        S_RELEASE: begin
          if (half_done) begin
            cnt_q <= 8'd0;
            if (!rel_phase_q) begin
              csn_q       <= 1'b1;
              rel_phase_q <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi_clk_o  = sck_q;
  assign spi_csn_o  = csn_q;
  assign spi_mosi_o = mosi_q;
  assign rx_byte_o  = rx_byte_q;
  assign rx_en_o    = rx_en_q;
  assign busy_o     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Directed self-checking bench for spi_master (HALF_PERIOD=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       spi_clk, spi_csn, spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_en = 1'b0;
  logic       cs_keep = 1'b0;
  logic       cs_release = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_en;
  logic       busy;
  logic [1:0] miso_mode = 2'd2;   // 0: tie low, 1: tie high, 2: loop MOSI

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // monitor state
  int csn_falls = 0, csn_rises = 0, sck_rises = 0, rx_cnt = 0, stab_err = 0;
  int csn_fall_cyc = 0, csn_rise_cyc = 0, rx_en_cyc = 0, busy_fall_cyc = 0;
  int first_rise_cyc = 0, last_rise_cyc = 0;
  logic first_pending = 1'b0;
  logic [7:0] mosi_bits = 8'h00;
  logic [7:0] last_rx = 8'h00;
  logic prev_csn = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0, prev_mosi = 1'b0;

  assign spi_miso = (miso_mode == 2'd2) ? spi_mosi : miso_mode[0];

  spi_master #(.HALF_PERIOD(3)) dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .spi_clk_o    (spi_clk),
    .spi_csn_o    (spi_csn),
    .spi_mosi_o   (spi_mosi),
    .spi_miso_i   (spi_miso),
    .tx_byte_i    (tx_byte),
    .tx_en_i      (tx_en),
    .cs_keep_i    (cs_keep),
    .cs_release_i (cs_release),
    .rx_byte_o    (rx_byte),
    .rx_en_o      (rx_en),
    .busy_o       (busy)
  );

  always #5 clk6x = ~clk6x;

  always @(posedge clk6x) cyc <= cyc + 1;

  // Record bus events, sampled on the inactive clock edge.
  always @(negedge clk6x) begin
    if (prev_csn && !spi_csn) begin
      csn_falls     <= csn_falls + 1;
      csn_fall_cyc  <= cyc;
      first_pending <= 1'b1;
    end
    if (!prev_csn && spi_csn) begin
      csn_rises    <= csn_rises + 1;
      csn_rise_cyc <= cyc;
    end
    if (!prev_sck && spi_clk) begin
      sck_rises     <= sck_rises + 1;
      mosi_bits     <= {mosi_bits[6:0], spi_mosi};
      last_rise_cyc <= cyc;
      if (spi_mosi !== prev_mosi) stab_err <= stab_err + 1;
      if (first_pending) begin
        first_rise_cyc <= cyc;
        first_pending  <= 1'b0;
      end
    end
    if (rx_en) begin
      rx_cnt    <= rx_cnt + 1;
      rx_en_cyc <= cyc;
      last_rx   <= rx_byte;
    end
    if (prev_busy && !busy) busy_fall_cyc <= cyc;
    prev_csn  <= spi_csn;
    prev_sck  <= spi_clk;
    prev_busy <= busy;
    prev_mosi <= spi_mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk6x);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic k);
    tx_byte = b;
    cs_keep = k;
    tx_en   = 1'b1;
    tick;
    tx_en   = 1'b0;
    tx_byte = 8'h00;
    cs_keep = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick;
    end
    check(tag, {31'd0, busy}, 32'd0);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rise, b_rx, b_fall, b_crise, c0;

    // ---- reset state
    repeat (3) tick;
    check("rst_sck",  {31'd0, spi_clk},  32'd0);
    check("rst_csn",  {31'd0, spi_csn},  32'd1);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check("rst_rxb",  {24'd0, rx_byte},  32'd0);
    check("rst_rxen", {31'd0, rx_en},    32'd0);
    check("rst_busy", {31'd0, busy},     32'd0);
    resetn = 1'b1;
    repeat (2) tick;

    // ---- loopback 0xA5, release after byte
    miso_mode = 2'd2;
    b_rise = sck_rises; b_rx = rx_cnt;
    send(8'hA5, 1'b0);
    check("a5_busy_start", {31'd0, busy}, 32'd1);
    check("a5_csn_low", {31'd0, spi_csn}, 32'd0);
    wait_idle("a5_timeout");
    check("a5_sck_rises", sck_rises - b_rise, 32'd8);
    check("a5_mosi_bits", {24'd0, mosi_bits}, 32'hA5);
    check("a5_mosi_stable", stab_err, 32'd0);
    check("a5_first_rise", first_rise_cyc - csn_fall_cyc, 32'd3);
    check("a5_sck_span", last_rise_cyc - first_rise_cyc, 32'd42);
    check("a5_rx_count", rx_cnt - b_rx, 32'd1);
    check("a5_rx_byte", {24'd0, last_rx}, 32'hA5);
    check("a5_latency", rx_en_cyc - csn_fall_cyc, 32'd48);
    check("a5_csn_rise", csn_rise_cyc - rx_en_cyc, 32'd3);
    check("a5_busy_fall", busy_fall_cyc - csn_rise_cyc, 32'd3);
    check("a5_csn_idle", {31'd0, spi_csn}, 32'd1);
    check("a5_mosi_hold", {31'd0, spi_mosi}, 32'd1);

    // ---- MISO tied high / low
    miso_mode = 2'd1;
    send(8'h00, 1'b0);
    wait_idle("ones_timeout");
    check("miso1_rx", {24'd0, last_rx}, 32'hFF);
    miso_mode = 2'd0;
    send(8'hFF, 1'b0);
    wait_idle("zeros_timeout");
    check("miso0_rx", {24'd0, last_rx}, 32'h00);
    check("ff_mosi_hold", {31'd0, spi_mosi}, 32'd1);

    // ---- two bytes with CSN held
    miso_mode = 2'd2;
    b_rise = sck_rises; b_rx = rx_cnt; b_fall = csn_falls; b_crise = csn_rises;
    send(8'h12, 1'b1);
    wait_idle("b12_timeout");
    check("b12_rx", {24'd0, last_rx}, 32'h12);
    check("b12_csn_held", {31'd0, spi_csn}, 32'd0);
    send(8'h34, 1'b0);
    wait_idle("b34_timeout");
    check("b34_rx", {24'd0, last_rx}, 32'h34);
    check("b34_mosi_bits", {24'd0, mosi_bits}, 32'h34);
    check("two_sck_rises", sck_rises - b_rise, 32'd16);
    check("two_rx_count", rx_cnt - b_rx, 32'd2);
    check("two_csn_falls", csn_falls - b_fall, 32'd1);
    check("two_csn_rises", csn_rises - b_crise, 32'd1);

    // ---- tx_en while busy is ignored
    b_rise = sck_rises; b_rx = rx_cnt;
    send(8'h5A, 1'b0);
    repeat (20) tick;
    tx_byte = 8'hFF; tx_en = 1'b1;
    tick;
    tx_en = 1'b0; tx_byte = 8'h00;
    wait_idle("ign_timeout");
    check("ign_mosi_bits", {24'd0, mosi_bits}, 32'h5A);
    check("ign_rx_count", rx_cnt - b_rx, 32'd1);
    check("ign_rx", {24'd0, last_rx}, 32'h5A);
    check("ign_sck_rises", sck_rises - b_rise, 32'd8);

    // ---- HOLD: tx_en and cs_release together, then release alone
    b_crise = csn_rises;
    send(8'h81, 1'b1);
    wait_idle("h81_timeout");
    tx_byte = 8'hC3; cs_keep = 1'b1; tx_en = 1'b1; cs_release = 1'b1;
    tick;
    tx_en = 1'b0; cs_release = 1'b0; cs_keep = 1'b0; tx_byte = 8'h00;
    check("both_busy", {31'd0, busy}, 32'd1);
    check("both_csn", {31'd0, spi_csn}, 32'd0);
    wait_idle("hc3_timeout");
    check("both_rx", {24'd0, last_rx}, 32'hC3);
    check("both_csn_held", {31'd0, spi_csn}, 32'd0);
    check("both_no_rise", csn_rises - b_crise, 32'd0);
    c0 = cyc;
    cs_release = 1'b1;
    tick;
    cs_release = 1'b0;
    check("rel_busy", {31'd0, busy}, 32'd1);
    wait_idle("rel_timeout");
    check("rel_csn_rise", csn_rise_cyc - c0, 32'd4);
    check("rel_busy_fall", busy_fall_cyc - c0, 32'd7);
    check("rel_csn_idle", {31'd0, spi_csn}, 32'd1);

    // ---- asynchronous reset during bit 3
    b_rise = sck_rises;
    send(8'hF0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (sck_rises - b_rise >= 4) break;
      tick;
    end
    check("mid_reached_bit3", sck_rises - b_rise, 32'd4);
    b_rx = rx_cnt;
    resetn = 1'b0;
    #1;
    check("arst_csn",  {31'd0, spi_csn},  32'd1);
    check("arst_sck",  {31'd0, spi_clk},  32'd0);
    check("arst_busy", {31'd0, busy},     32'd0);
    check("arst_rxen", {31'd0, rx_en},    32'd0);
    check("arst_mosi", {31'd0, spi_mosi}, 32'd0);
    repeat (3) tick;
    resetn = 1'b1;
    repeat (2) tick;
    check("arst_no_rx", rx_cnt - b_rx, 32'd0);
    send(8'h3C, 1'b0);
    wait_idle("r3c_timeout");
    check("r3c_rx", {24'd0, last_rx}, 32'h3C);
    check("r3c_rx_count", rx_cnt - b_rx, 32'd1);
    check("r3c_mosi_bits", {24'd0, mosi_bits}, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
